uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (tx_byte / tx_send / tx_ready) among N on-chip requesters: debug echo, status reporter, host-command responder.
- Round-robin arbitration with packet lock. Once a requester wins, it keeps the transmitter until it sends a byte flagged last.
- Sits between the requesters and the uart instance in the clock25 domain. It replaces the hand-written txb/txs register logic in the top level.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_arb_pkg;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   // Idle cycles with tx_send low between frames so the uart sees a fresh edge
   localparam int GAP_CYCLES = 1;

   // Next round-robin index after idx, wrapping at n-1 -> 0
   function automatic logic [31:0] rr_next(input logic [31:0] idx, input logic [31:0] n);
      if (idx + 32'd1 >= n) begin
         rr_next = '0;
      end else begin
         rr_next = idx + 32'd1;
      end
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot winner, first set req at or above ptr_i, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is consumed.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o
);

   // Two passes: indices from ptr upward first, then the wrapped range below ptr
   always_comb begin
      logic found;
      grant_o = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (IW'(i) >= ptr_i)) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (IW'(i) < ptr_i)) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among N requesters, round-robin with packet lock until a last byte.
// Latency: tx_send rises 1 cycle after req is seen in IDLE; ack pulses 1 cycle after tx_ready.
// Backpressure: requesters hold req until ack; SEND waits for tx_ready (bounded when UART_TX_ARB_TIMEOUT_EN).
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N       = 3,
   parameter int TIMEOUT = 4096
) (
   input  logic           clock25,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [8*N-1:0] req_byte,
   input  logic [N-1:0]   req_last,
   output logic [N-1:0]   ack,
   output logic [N-1:0]   grant,
   output logic [7:0]     tx_byte,
   output logic           tx_send,
   input  logic           tx_ready,
   output logic           busy
`ifdef UART_TX_ARB_TIMEOUT_EN
   ,
   output logic           timeout_err,
   input  logic           err_clr
`endif
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if (N < 1 || N > 8) begin : g_bad_n
      $error("uart_tx_arbiter: N must be in 1..8");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("uart_tx_arbiter: TIMEOUT must be at least 2");
   end

   arb_state_t     state_q, state_d;
   logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]  owner_q, owner_d;
   logic           locked_q, locked_d;
   logic           last_q, last_d;
   logic           tx_send_q, tx_send_d;
   logic [7:0]     tx_byte_q, tx_byte_d;
   logic [N-1:0]   grant_q, grant_d;
   logic [N-1:0]   ack_q, ack_d;
   logic [3:0]     gap_q, gap_d;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT) + 1;
   logic [TW-1:0]  cnt_q, cnt_d;
   logic           terr_q, terr_d;
`endif

   logic [N-1:0]   win;
   logic [IW-1:0]  win_idx;
   logic [7:0]     win_byte;
   logic           win_last;
   logic           own_req;
   logic [7:0]     own_byte;
   logic           own_last;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req_i   (req),
      .ptr_i   (rr_ptr_q),
      .grant_o (win)
   );

   // Select the winner's and the current owner's request fields
   always_comb begin
      win_idx  = '0;
      win_byte = '0;
      win_last = 1'b0;
      own_req  = 1'b0;
      own_byte = '0;
      own_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (win[i]) begin
            win_idx  = IW'(i);
            win_byte = req_byte[8*i +: 8];
            win_last = req_last[i];
         end
         if (owner_q == IW'(i)) begin
            own_req  = req[i];
            own_byte = req_byte[8*i +: 8];
            own_last = req_last[i];
         end
      end
   end

   // Next-state: launch a byte, wait for the frame, then a short gap
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      locked_d  = locked_q;
      last_d    = last_q;
      tx_send_d = tx_send_q;
      tx_byte_d = tx_byte_q;
      grant_d   = grant_q;
      ack_d     = '0;
      gap_d     = gap_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      terr_d    = terr_q;
      if (err_clr) begin
         terr_d = 1'b0;
      end
`endif
      case (state_q)
         IDLE: begin
            if (locked_q) begin
               // Owner keeps the transmitter, even while its req is low
               if (own_req) begin
                  tx_byte_d = own_byte;
                  last_d    = own_last;
                  tx_send_d = 1'b1;
                  state_d   = SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  cnt_d     = '0;
`endif
               end
            end else if (|win) begin
               grant_d   = win;
               owner_d   = win_idx;
               tx_byte_d = win_byte;
               last_d    = win_last;
               tx_send_d = 1'b1;
               state_d   = SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         SEND: begin
            if (tx_ready) begin
               ack_d     = grant_q;
               tx_send_d = 1'b0;
               gap_d     = '0;
               state_d   = GAP;
               if (last_q) begin
                  locked_d = 1'b0;
                  grant_d  = '0;
                  rr_ptr_d = IW'(rr_next(32'(owner_q), 32'(N)));
               end else begin
                  locked_d = 1'b1;
               end
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (cnt_q == TW'(TIMEOUT - 1)) begin
               // Uart never answered: abandon the packet and flag it
               tx_send_d = 1'b0;
               locked_d  = 1'b0;
               grant_d   = '0;
               rr_ptr_d  = IW'(rr_next(32'(owner_q), 32'(N)));
               gap_d     = '0;
               state_d   = GAP;
               terr_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         GAP: begin
            if (gap_q == 4'(GAP_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset returns every output to idle at once
   always_ff @(posedge clock25 or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         locked_q  <= 1'b0;
         last_q    <= 1'b0;
         tx_send_q <= 1'b0;
         tx_byte_q <= 8'h00;
         grant_q   <= '0;
         ack_q     <= '0;
         gap_q     <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         terr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         locked_q  <= locked_d;
         last_q    <= last_d;
         tx_send_q <= tx_send_d;
         tx_byte_q <= tx_byte_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         gap_q     <= gap_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         terr_q    <= terr_d;
`endif
      end
   end

   assign ack     = ack_q;
   assign grant   = grant_q;
   assign tx_byte = tx_byte_q;
   assign tx_send = tx_send_q;
   assign busy    = (state_q != IDLE) || locked_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
   assign timeout_err = terr_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a uart model and a scoreboard on sends and acks.
// Latency: uart model answers tx_send with a tx_ready pulse 10 cycles later.
// Backpressure: requesters hold each byte until its ack.
module tb_uart_tx_arbiter;

   localparam int N        = 3;
   localparam int UART_CYC = 10;

   logic           clock25;
   logic           reset;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_byte;
   logic [N-1:0]   req_last;
   logic [N-1:0]   ack;
   logic [N-1:0]   grant;
   logic [7:0]     tx_byte;
   logic           tx_send;
   logic           tx_ready;
   logic           busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
   logic           timeout_err;
   logic           err_clr;
`endif

   uart_tx_arbiter #(.N(N), .TIMEOUT(16)) dut (
      .clock25  (clock25),
      .reset    (reset),
      .req      (req),
      .req_byte (req_byte),
      .req_last (req_last),
      .ack      (ack),
      .grant    (grant),
      .tx_byte  (tx_byte),
      .tx_send  (tx_send),
      .tx_ready (tx_ready),
      .busy     (busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
      ,
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
`endif
   );

   typedef struct packed {
      logic [7:0]   b;
      logic [N-1:0] g;
   } tx_exp_t;

   tx_exp_t      exp_tx[$];
   logic [N-1:0] exp_ack[$];
   logic [8:0]   q0[$], q1[$], q2[$];

   int   checks = 0;
   int   errors = 0;
   int   ack_cnt = 0;
   int   rdy_cnt = 0;
   logic uart_en = 1'b1;
   logic uart_busy = 1'b0;
   int   uart_cnt = 0;
   logic prev_send = 1'b0;
   tx_exp_t mon_e;

   initial clock25 = 1'b0;
   always #5 clock25 = ~clock25;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_tx(input int id, input logic [7:0] b, input bit with_ack);
      tx_exp_t e;
      e.b = b;
      e.g = N'(1) << id;
      exp_tx.push_back(e);
      if (with_ack) exp_ack.push_back(N'(1) << id);
   endtask

   task automatic load(input int id, input logic [7:0] b, input logic last);
      case (id)
         0:       q0.push_back({last, b});
         1:       q1.push_back({last, b});
         default: q2.push_back({last, b});
      endcase
   endtask

   task automatic sync();
      @(posedge clock25);
      #2;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_tx.size() > 0 || exp_ack.size() > 0 || q0.size() > 0 || q1.size() > 0 ||
              q2.size() > 0 || busy !== 1'b0) && n < 3000) begin
         @(negedge clock25);
         n++;
      end
      chk(name, 32'(n < 3000), 32'd1);
   endtask

   task automatic reset_dut();
      @(negedge clock25);
      reset = 1'b1;
      @(negedge clock25);
      @(negedge clock25);
      reset = 1'b0;
   endtask

   // Scoreboard monitor: every send start and every ack pops one expectation
   always @(negedge clock25) begin
      if (tx_send === 1'b1 && prev_send !== 1'b1) begin
         if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_send: got byte %0h grant %0b expected none", tx_byte, grant);
         end else begin
            mon_e = exp_tx.pop_front();
            chk("send_byte", 32'(tx_byte), 32'(mon_e.b));
            chk("send_grant", 32'(grant), 32'(mon_e.g));
         end
      end
      prev_send = tx_send;
      if (ack !== '0) begin
         ack_cnt++;
         if (exp_ack.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got %0b expected none", ack);
         end else begin
            chk("ack", 32'(ack), 32'(exp_ack.pop_front()));
         end
      end
   end

   // Requester model: present queue heads, retire a head on its ack
   always @(negedge clock25) begin
      if (ack[0] === 1'b1 && q0.size() > 0) q0.delete(0);
      if (ack[1] === 1'b1 && q1.size() > 0) q1.delete(0);
      if (ack[2] === 1'b1 && q2.size() > 0) q2.delete(0);
      req[0] = (q0.size() > 0);
      req[1] = (q1.size() > 0);
      req[2] = (q2.size() > 0);
      {req_last[0], req_byte[7:0]}   = (q0.size() > 0) ? q0[0] : 9'h0;
      {req_last[1], req_byte[15:8]}  = (q1.size() > 0) ? q1[0] : 9'h0;
      {req_last[2], req_byte[23:16]} = (q2.size() > 0) ? q2[0] : 9'h0;
   end

   // Uart model: tx_ready pulse a fixed time after tx_send is seen, regardless of reset
   always @(negedge clock25) begin
      tx_ready = 1'b0;
      if (uart_busy) begin
         uart_cnt++;
         if (uart_cnt == UART_CYC) begin
            tx_ready  = 1'b1;
            uart_busy = 1'b0;
            rdy_cnt++;
         end
      end else if (tx_send === 1'b1 && uart_en) begin
         uart_busy = 1'b1;
         uart_cnt  = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int a0;
      int r0;
      int bad;
      reset    = 1'b0;
      req      = '0;
      req_byte = '0;
      req_last = '0;
      tx_ready = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      err_clr  = 1'b0;
`endif
      #1 reset = 1'b1;
      #2;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_send", 32'(tx_send), 32'd0);
      chk("rst_byte", 32'(tx_byte), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clock25);
      reset = 1'b0;

      // Single byte, one-cycle launch latency
      sync();
      expect_tx(0, 8'h42, 1'b1);
      load(0, 8'h42, 1'b1);
      @(negedge clock25);
      chk("lat_early_send", 32'(tx_send), 32'd0);
      @(posedge clock25);
      #1;
      chk("lat_send", 32'(tx_send), 32'd1);
      chk("lat_byte", 32'(tx_byte), 32'h42);
      chk("lat_grant", 32'(grant), 32'b001);
      chk("lat_busy", 32'(busy), 32'd1);
      n = 0;
      while (ack === '0 && n < 100) begin
         @(negedge clock25);
         n++;
      end
      chk("single_ack_seen", 32'(n < 100), 32'd1);
      chk("single_post_grant", 32'(grant), 32'd0);
      chk("single_post_send", 32'(tx_send), 32'd0);
      wait_drain("single_drain");

      // Round-robin from pointer 0 with requester 0 holding a second byte
      reset_dut();
      sync();
      expect_tx(0, 8'hA0, 1'b1);
      expect_tx(1, 8'hA1, 1'b1);
      expect_tx(2, 8'hA2, 1'b1);
      expect_tx(0, 8'hA0, 1'b1);
      load(0, 8'hA0, 1'b1);
      load(0, 8'hA0, 1'b1);
      load(1, 8'hA1, 1'b1);
      load(2, 8'hA2, 1'b1);
      wait_drain("rr_drain");

      // Packet lock: pointer is 1, requester 1 keeps the link for 3 bytes
      sync();
      expect_tx(1, 8'h11, 1'b1);
      expect_tx(1, 8'h12, 1'b1);
      expect_tx(1, 8'h13, 1'b1);
      expect_tx(0, 8'h07, 1'b1);
      load(1, 8'h11, 1'b0);
      load(1, 8'h12, 1'b0);
      load(1, 8'h13, 1'b1);
      load(0, 8'h07, 1'b1);
      n = 0;
      bad = 0;
      while (exp_ack.size() > 1 && n < 1000) begin
         @(negedge clock25);
         if (grant !== 3'b000 && grant !== 3'b010) bad++;
         n++;
      end
      chk("lock_grant_stable", 32'(bad), 32'd0);
      wait_drain("lock_drain");

      // Owner stall: requester 2 locked, then silent while requester 0 waits
      sync();
      expect_tx(2, 8'h55, 1'b1);
      load(2, 8'h55, 1'b0);
      n = 0;
      while (exp_ack.size() > 0 && n < 200) begin
         @(negedge clock25);
         n++;
      end
      chk("stall_first_ack", 32'(n < 200), 32'd1);
      sync();
      load(0, 8'h09, 1'b1);
      repeat (20) @(negedge clock25);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_send", 32'(tx_send), 32'd0);
      chk("stall_grant", 32'(grant), 32'b100);
      sync();
      expect_tx(2, 8'h56, 1'b1);
      expect_tx(0, 8'h09, 1'b1);
      load(2, 8'h56, 1'b1);
      wait_drain("stall_drain");

      // Reset while a frame is in flight; the later tx_ready must be ignored
      sync();
      expect_tx(0, 8'h77, 1'b0);
      load(0, 8'h77, 1'b1);
      n = 0;
      while (tx_send !== 1'b1 && n < 100) begin
         @(posedge clock25);
         #1;
         n++;
      end
      chk("midrst_send_seen", 32'(n < 100), 32'd1);
      repeat (3) @(posedge clock25);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_send", 32'(tx_send), 32'd0);
      chk("midrst_grant", 32'(grant), 32'd0);
      chk("midrst_byte", 32'(tx_byte), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ack", 32'(ack), 32'd0);
      q0.delete();
      a0 = ack_cnt;
      r0 = rdy_cnt;
      repeat (2) @(negedge clock25);
      reset = 1'b0;
      repeat (20) @(negedge clock25);
      chk("stray_rdy_seen", 32'(rdy_cnt - r0), 32'd1);
      chk("stray_no_ack", 32'(ack_cnt - a0), 32'd0);
      chk("stray_idle_send", 32'(tx_send), 32'd0);
      chk("stray_idle_busy", 32'(busy), 32'd0);

`ifdef UART_TX_ARB_TIMEOUT_EN
      // Timeout: no uart answer, abandon after 16 cycles, serve the next requester
      reset_dut();
      sync();
      uart_en = 1'b0;
      expect_tx(0, 8'hE1, 1'b0);
      expect_tx(1, 8'hE2, 1'b1);
      expect_tx(0, 8'hE1, 1'b1);
      load(0, 8'hE1, 1'b1);
      load(1, 8'hE2, 1'b1);
      a0 = ack_cnt;
      n = 0;
      while (tx_send !== 1'b1 && n < 100) begin
         @(posedge clock25);
         #1;
         n++;
      end
      chk("to_send_seen", 32'(n < 100), 32'd1);
      n = 0;
      while (tx_send === 1'b1 && n < 100) begin
         @(posedge clock25);
         #1;
         n++;
      end
      uart_en = 1'b1;
      chk("to_len", 32'(n), 32'd16);
      chk("to_err", 32'(timeout_err), 32'd1);
      chk("to_no_ack", 32'(ack_cnt - a0), 32'd0);
      @(negedge clock25);
      err_clr = 1'b1;
      @(negedge clock25);
      err_clr = 1'b0;
      chk("to_err_clr", 32'(timeout_err), 32'd0);
      wait_drain("to_drain");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
